// File: rtl/usb_burst_pkg.sv
// Shared constants, state encodings and payload pattern helpers
// for the USB command-driven burst generator.
package usb_burst_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] HDR_BYTE  = 8'h5A;
  localparam logic [7:0] OP_INC    = 8'h01;
  localparam logic [7:0] OP_ALT    = 8'h02;

  typedef enum logic [1:0] {
    P_SYNC,
    P_OP,
    P_LENH,
    P_LENL
  } parse_state_e;

  typedef enum logic [2:0] {
    G_IDLE,
    G_HDR,
    G_LENH,
    G_LENL,
    G_DATA,
    G_SUM
  } gen_state_e;

  function automatic logic [7:0] first_pat(input logic [7:0] op);
    return (op == OP_ALT) ? 8'h55 : 8'h00;
  endfunction

  function automatic logic [7:0] next_pat(input logic [7:0] op,
                                          input logic [7:0] p);
    return (op == OP_ALT) ? ~p : p + 8'd1;
  endfunction

endpackage

// File: rtl/usb_cmd_parser.sv
// Parses 4-byte host commands (sync, opcode, LEN) with an
// inter-byte timeout; emits a one-cycle start or a cmd_err pulse.
module usb_cmd_parser #(
  parameter int CMD_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fire_i,
  input  logic [7:0]  rx_data_i,
  output logic        start_o,
  output logic [7:0]  op_o,
  output logic [15:0] len_o,
  output logic        cmd_err_o
);
  import usb_burst_pkg::*;

  localparam int TW = $clog2(CMD_TIMEOUT + 1);

  parse_state_e  state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    lenh_q, lenh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          op_ok;
  logic          tmo_hit;

  assign op_ok   = (op_q == OP_INC) || (op_q == OP_ALT);
  assign tmo_hit = (tmo_q == TW'(CMD_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lenh_d  = lenh_q;
    err_d   = 1'b0;
    start_o = 1'b0;
    if (state_q == P_SYNC || rx_fire_i) tmo_d = '0;
    else                                tmo_d = tmo_q + 1'b1;
    unique case (state_q)
      P_SYNC: if (rx_fire_i && rx_data_i == SYNC_BYTE) state_d = P_OP;
      P_OP: if (rx_fire_i) begin
        op_d    = rx_data_i;
        state_d = P_LENH;
      end
      P_LENH: if (rx_fire_i) begin
        lenh_d  = rx_data_i;
        state_d = P_LENL;
      end
      P_LENL: if (rx_fire_i) begin
        state_d = P_SYNC;
        start_o = op_ok;
        err_d   = ~op_ok;
      end
      default: state_d = P_SYNC;
    endcase
    // A stalled partial command is dropped so the next sync can resync
    if (state_q != P_SYNC && !rx_fire_i && tmo_hit) begin
      state_d = P_SYNC;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= P_SYNC;
      op_q    <= '0;
      lenh_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lenh_q  <= lenh_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign op_o      = op_q;
  assign len_o     = {lenh_q, rx_data_i};
  assign cmd_err_o = err_q;

endmodule

// File: rtl/usb_cmd_burst_gen.sv
// Host-commanded burst source between the RX and TX user ports of
// ftdi_245fifo: frame = 5A, LEN, payload, XOR checksum.
module usb_cmd_burst_gen #(
  parameter int CMD_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       otvalid,
  output logic       otready,
  input  logic [7:0] otdata,
  output logic       itvalid,
  input  logic       itready,
  output logic [7:0] itdata,
  output logic       busy,
  output logic       cmd_err,
  output logic       burst_done
);
  import usb_burst_pkg::*;

  gen_state_e  gst_q, gst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  dat_q, dat_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        rx_fire, tx_fire, start;
  logic [7:0]  p_op;
  logic [15:0] p_len;

  assign rx_fire = otvalid & rdy_q;
  assign tx_fire = vld_q & itready;

  usb_cmd_parser #(
    .CMD_TIMEOUT(CMD_TIMEOUT)
  ) u_parser (
    .clk       (clk),
    .rst       (rst),
    .rx_fire_i (rx_fire),
    .rx_data_i (otdata),
    .start_o   (start),
    .op_o      (p_op),
    .len_o     (p_len),
    .cmd_err_o (cmd_err)
  );

  always_comb begin
    gst_d  = gst_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    pat_d  = pat_q;
    xor_d  = xor_q;
    dat_d  = dat_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    unique case (gst_q)
      G_IDLE: if (start) begin
        gst_d = G_HDR;
        op_d  = p_op;
        cnt_d = p_len;
        pat_d = first_pat(p_op);
        xor_d = '0;
        dat_d = HDR_BYTE;
        vld_d = 1'b1;
      end
      G_HDR: if (tx_fire) begin
        gst_d = G_LENH;
        dat_d = cnt_q[15:8];
      end
      G_LENH: if (tx_fire) begin
        gst_d = G_LENL;
        dat_d = cnt_q[7:0];
      end
      G_LENL: if (tx_fire) begin
        if (cnt_q == 16'd0) begin
          gst_d = G_SUM;
          dat_d = xor_q;
        end else begin
          gst_d = G_DATA;
          dat_d = pat_q;
        end
      end
      G_DATA: if (tx_fire) begin
        xor_d = xor_q ^ dat_q;
        pat_d = next_pat(op_q, pat_q);
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          gst_d = G_SUM;
          dat_d = xor_d;
        end else begin
          dat_d = pat_d;
        end
      end
      G_SUM: if (tx_fire) begin
        gst_d  = G_IDLE;
        vld_d  = 1'b0;
        dat_d  = '0;
        done_d = 1'b1;
      end
      default: gst_d = G_IDLE;
    endcase
    // RX is held off for the whole burst: no command queuing
    busy_d = (gst_d != G_IDLE);
    rdy_d  = ~busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gst_q  <= G_IDLE;
      cnt_q  <= '0;
      op_q   <= '0;
      pat_q  <= '0;
      xor_q  <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      gst_q  <= gst_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      pat_q  <= pat_d;
      xor_q  <= xor_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
    end
  end

  assign otready    = rdy_q;
  assign itvalid    = vld_q;
  assign itdata     = dat_q;
  assign busy       = busy_q;
  assign burst_done = done_q;

endmodule

// File: tb/tb_usb_cmd_burst_gen.sv
// Directed bench for usb_cmd_burst_gen: frames, backpressure,
// bad opcode, timeout, zero length, wrap and mid-burst reset.
module tb_usb_cmd_burst_gen;

  typedef logic [7:0] u8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       otvalid = 1'b0;
  logic [7:0] otdata = 8'h00;
  logic       itready = 1'b0;
  logic       otready;
  logic       itvalid;
  logic [7:0] itdata;
  logic       busy;
  logic       cmd_err;
  logic       burst_done;

  int tests = 0;
  int fails = 0;

  u8_t cap[$];
  int  cap_first;
  int  cap_last;
  int  cap_stall;
  int  cap_dones;

  always #5 clk = ~clk;

  usb_cmd_burst_gen #(
    .CMD_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .otvalid    (otvalid),
    .otready    (otready),
    .otdata     (otdata),
    .itvalid    (itvalid),
    .itready    (itready),
    .itdata     (itdata),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .burst_done (burst_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one RX byte until accepted (bounded wait)
  task automatic send_byte(input u8_t b);
    int  w;
    bit  ok;
    w = 0;
    ok = 1'b0;
    otvalid = 1'b1;
    otdata  = b;
    while (!ok && w < 100) begin
      ok = otready;
      tick();
      w++;
    end
    otvalid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rx_accept %02h: otready 0, required 1 within 100 cycles", b);
    end
  endtask

  // Drive itready from a 4-cycle pattern and record TX transfers
  task automatic capture(input logic [3:0] pat, input int maxcyc);
    u8_t prev;
    bit  stalled;
    cap.delete();
    cap_first = -1;
    cap_last  = -1;
    cap_stall = 0;
    cap_dones = 0;
    stalled   = 1'b0;
    prev      = 8'h00;
    for (int c = 0; c < maxcyc; c++) begin
      if (stalled && (itvalid !== 1'b1 || itdata !== prev)) cap_stall++;
      if (burst_done === 1'b1) cap_dones++;
      itready = pat[c % 4];
      if (itvalid === 1'b1 && itready) begin
        cap.push_back(itdata);
        if (cap_first < 0) cap_first = c;
        cap_last = c;
      end
      stalled = (itvalid === 1'b1) && !itready;
      prev    = itdata;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({otready, itvalid, busy, cmd_err, burst_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {otready, itvalid, busy, cmd_err, burst_done});
    end
    tests++;
    if (itdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_itdata: got %02h, required 00", itdata);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (otready !== 1'b1) begin
      fails++;
      $display("FAIL otready_rise: got %b, required 1", otready);
    end
  endtask

  task automatic test_inc();
    u8_t e[8] = '{8'h5A, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    int  bi;
    itready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h04);
    tests++;
    if ({otready, busy, itvalid} !== 3'b011 || itdata !== 8'h5A) begin
      fails++;
      $display("FAIL inc_first: rdy/busy/vld %b data %02h, required 011 5a",
               {otready, busy, itvalid}, itdata);
    end
    capture(4'b1111, 20);
    bi = -1;
    foreach (e[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== e[i])) bi = i;
    tests++;
    if (cap.size() != 8 || bi >= 0) begin
      fails++;
      $display("FAIL inc_frame: got %0d bytes, first bad idx %0d, required 8 matching",
               cap.size(), bi);
    end
    tests++;
    if (cap_last - cap_first != 7) begin
      fails++;
      $display("FAIL inc_throughput: got span %0d cycles, required 8",
               cap_last - cap_first + 1);
    end
    tests++;
    if (cap_dones != 1) begin
      fails++;
      $display("FAIL inc_done: got %0d pulses, required 1", cap_dones);
    end
    tests++;
    if ({otready, busy, itvalid} !== 3'b100) begin
      fails++;
      $display("FAIL inc_after: rdy/busy/vld %b, required 100",
               {otready, busy, itvalid});
    end
  endtask

  task automatic test_alt_backpressure();
    u8_t e[7] = '{8'h5A, 8'h00, 8'h03, 8'h55, 8'hAA, 8'h55, 8'hAA};
    int  bi;
    send_byte(8'h13);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h03);
    capture(4'b1001, 40);
    bi = -1;
    foreach (e[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== e[i])) bi = i;
    tests++;
    if (cap.size() != 7 || bi >= 0) begin
      fails++;
      $display("FAIL alt_frame: got %0d bytes, first bad idx %0d, required 7 matching",
               cap.size(), bi);
    end
    tests++;
    if (cap_stall != 0) begin
      fails++;
      $display("FAIL alt_stall: got %0d unstable stalls, required 0", cap_stall);
    end
    tests++;
    if (cap_dones != 1) begin
      fails++;
      $display("FAIL alt_done: got %0d pulses, required 1", cap_dones);
    end
  endtask

  task automatic test_bad_opcode();
    u8_t e[5] = '{8'h5A, 8'h00, 8'h01, 8'h00, 8'h00};
    int  bi;
    int  vhi;
    itready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h04);
    tests++;
    if (cmd_err !== 1'b1 || otready !== 1'b1) begin
      fails++;
      $display("FAIL badop_err: cmd_err %b otready %b, required 1 1", cmd_err, otready);
    end
    vhi = 0;
    tick();
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL badop_pulse: cmd_err %b, required 0", cmd_err);
    end
    for (int k = 0; k < 5; k++) begin
      if (itvalid !== 1'b0 || otready !== 1'b1) vhi++;
      tick();
    end
    tests++;
    if (vhi != 0) begin
      fails++;
      $display("FAIL badop_quiet: got %0d bad cycles, required 0", vhi);
    end
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    capture(4'b1111, 15);
    bi = -1;
    foreach (e[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== e[i])) bi = i;
    tests++;
    if (cap.size() != 5 || bi >= 0) begin
      fails++;
      $display("FAIL badop_next_frame: got %0d bytes, first bad idx %0d, required 5 matching",
               cap.size(), bi);
    end
  endtask

  task automatic test_timeout_zero();
    u8_t e[4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    int  bi;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (15) tick();
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_early: cmd_err %b at cycle 15, required 0", cmd_err);
    end
    tick();
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL tmo_fire: cmd_err %b at cycle 16, required 1", cmd_err);
    end
    tick();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    capture(4'b1111, 12);
    bi = -1;
    foreach (e[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== e[i])) bi = i;
    tests++;
    if (cap.size() != 4 || bi >= 0) begin
      fails++;
      $display("FAIL zero_frame: got %0d bytes, first bad idx %0d, required 4 matching",
               cap.size(), bi);
    end
    tests++;
    if (cap_dones != 1) begin
      fails++;
      $display("FAIL zero_done: got %0d pulses, required 1", cap_dones);
    end
  endtask

  task automatic test_long_wrap_reset();
    u8_t e[262];
    u8_t f[6] = '{8'h5A, 8'h00, 8'h02, 8'h55, 8'hAA, 8'hFF};
    int  bi;
    e[0] = 8'h5A;
    e[1] = 8'h01;
    e[2] = 8'h02;
    for (int i = 0; i < 258; i++) e[3 + i] = u8_t'(i);
    e[261] = 8'h01;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    capture(4'b1111, 280);
    bi = -1;
    foreach (e[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== e[i])) bi = i;
    tests++;
    if (cap.size() != 262 || bi >= 0) begin
      fails++;
      $display("FAIL long_frame: got %0d bytes, first bad idx %0d, required 262 matching",
               cap.size(), bi);
    end
    tests++;
    if (cap.size() < 262 || cap[259] !== 8'h00 || cap[261] !== 8'h01) begin
      fails++;
      $display("FAIL long_wrap_chk: size %0d, required byte259=00 chk=01", cap.size());
    end
    itready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (50) tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({otready, itvalid, busy, cmd_err, burst_done} !== 5'b0 || itdata !== 8'h00) begin
      fails++;
      $display("FAIL midburst_reset: ctrl %b data %02h, required 00000 00",
               {otready, itvalid, busy, cmd_err, burst_done}, itdata);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    capture(4'b1111, 15);
    bi = -1;
    foreach (f[i]) if (bi < 0 && (i >= cap.size() || cap[i] !== f[i])) bi = i;
    tests++;
    if (cap.size() != 6 || bi >= 0) begin
      fails++;
      $display("FAIL post_reset_frame: got %0d bytes, first bad idx %0d, required 6 matching",
               cap.size(), bi);
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_alt_backpressure();
    test_bad_opcode();
    test_timeout_zero();
    test_long_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
